// File: rtl/bignum_operand_loader_if.sv
// Bundle of the loader's word-input handshake and multiplier-side signals.
// The loader is the slave and the surrounding logic is the master.
//
// Handshake: a word on in_value/in_sel moves into the loader on every rising
// edge where in_valid && in_ready are both high. in_ready depends only on the
// loader state and never on in_valid. The multiplier side uses one-cycle
// pulses: mul_start from the loader and mul_done back from the multiplier.
interface bignum_operand_loader_if #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 32
);
    localparam int OP_W  = WORD_W * WORDS;
    localparam int PTR_W = $clog2(WORDS);

    logic              in_valid;
    logic [WORD_W-1:0] in_value;
    logic              in_sel;
    logic              in_ready;
    logic              clear;
    logic              commit;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [PTR_W-1:0]  ptr_a;
    logic [PTR_W-1:0]  ptr_b;
    logic              full_a;
    logic              full_b;
    logic              mul_start;
    logic              mul_done;
    logic              busy;
    logic [1:0]        state_dbg;

    modport master (
        output in_valid, in_value, in_sel, clear, commit, mul_done,
        input  in_ready, op_a, op_b, ptr_a, ptr_b, full_a, full_b,
               mul_start, busy, state_dbg
    );

    modport slave (
        input  in_valid, in_value, in_sel, clear, commit, mul_done,
        output in_ready, op_a, op_b, ptr_a, ptr_b, full_a, full_b,
               mul_start, busy, state_dbg
    );
endinterface

// File: rtl/bignum_operand_loader.sv
// Assembles the two wide multiplicands word by word and hands them to the
// parallel multiplier. The operands stay frozen from commit until mul_done.
// Optional feature macro: LOADER_AUTOSTART_EN. When it is defined, the cycle
// that completes both operands acts as an implicit commit, and both full
// flags clear when the multiplier finishes.
module bignum_operand_loader #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 32
) (
    input  logic clk,
    input  logic resetn,
    bignum_operand_loader_if.slave bus
);
    localparam int OP_W  = WORD_W * WORDS;
    localparam int PTR_W = $clog2(WORDS);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              mul_start_q;

    logic [OP_W-1:0]   op_a_q, op_a_d;
    logic [OP_W-1:0]   op_b_q, op_b_d;
    logic [PTR_W-1:0]  ptr_a_q, ptr_a_d;
    logic [PTR_W-1:0]  ptr_b_q, ptr_b_d;
    logic              full_a_q, full_a_d;
    logic              full_b_q, full_b_d;
    logic              accept;
    logic              go;

    // Next operand contents: clear wins over a write to the same operand; a
    // word written together with commit lands before the multiplier starts.
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        ptr_a_d  = ptr_a_q;
        ptr_b_d  = ptr_b_q;
        full_a_d = full_a_q;
        full_b_d = full_b_q;
        accept   = bus.in_valid && in_ready_q;

        if (state_q == S_LOAD) begin
            if (bus.clear && !bus.in_sel) begin
                op_a_d   = '0;
                ptr_a_d  = '0;
                full_a_d = 1'b0;
            end else if (accept && !bus.in_sel) begin
                op_a_d[int'(ptr_a_q)*WORD_W +: WORD_W] = bus.in_value;
                ptr_a_d = (ptr_a_q == LAST) ? '0 : ptr_a_q + PTR_W'(1);
                if (ptr_a_q == LAST) full_a_d = 1'b1;
            end

            if (bus.clear && bus.in_sel) begin
                op_b_d   = '0;
                ptr_b_d  = '0;
                full_b_d = 1'b0;
            end else if (accept && bus.in_sel) begin
                op_b_d[int'(ptr_b_q)*WORD_W +: WORD_W] = bus.in_value;
                ptr_b_d = (ptr_b_q == LAST) ? '0 : ptr_b_q + PTR_W'(1);
                if (ptr_b_q == LAST) full_b_d = 1'b1;
            end
        end

`ifdef LOADER_AUTOSTART_EN
        // Re-arm the implicit start for the next pair of operands.
        if (state_q == S_WAIT && bus.mul_done) begin
            full_a_d = 1'b0;
            full_b_d = 1'b0;
        end
`endif
    end

    // Start request: explicit commit, or (optionally) both operands just completed.
    always_comb begin
        go = 1'b0;
        if (state_q == S_LOAD) begin
            go = bus.commit;
`ifdef LOADER_AUTOSTART_EN
            if (full_a_d && full_b_d && !(full_a_q && full_b_q)) go = 1'b1;
`endif
        end
    end

    // Operand storage, pointers and full flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            ptr_a_q  <= '0;
            ptr_b_q  <= '0;
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
        end else begin
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            ptr_a_q  <= ptr_a_d;
            ptr_b_q  <= ptr_b_d;
            full_a_q <= full_a_d;
            full_b_q <= full_b_d;
        end
    end

    // Control FSM with registered in_ready/busy/mul_start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_LOAD;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (go) begin
                        state_q    <= S_ISSUE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q     <= S_WAIT;
                    mul_start_q <= 1'b1;
                end
                S_WAIT: begin
                    mul_start_q <= 1'b0;
                    if (bus.mul_done) begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_LOAD;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    mul_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.mul_start = mul_start_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.ptr_a     = ptr_a_q;
    assign bus.ptr_b     = ptr_b_q;
    assign bus.full_a    = full_a_q;
    assign bus.full_b    = full_b_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_bignum_operand_loader.sv
// Bench for bignum_operand_loader: fixed vector table, directed multi-cycle
// sequences and randomized traffic against a word-array reference model.
module tb_bignum_operand_loader;
  localparam int WORD_W = 32;
  localparam int WORDS  = 32;
  localparam int OP_W   = WORD_W * WORDS;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  bignum_operand_loader_if #(.WORD_W(WORD_W), .WORDS(WORDS)) bus ();

  bignum_operand_loader #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: operands as word arrays, plain integer pointers
  logic [WORD_W-1:0] ma[WORDS];
  logic [WORD_W-1:0] mb[WORDS];
  int pa, pb;
  bit fa, fb;

  typedef struct {
    bit v; bit sel; bit clr; bit md;
    logic [31:0] val;
    int exp_pa; int exp_pb;
    logic [31:0] exp_a0; logic [31:0] exp_b0;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_op(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
    bit found;
    checks++;
    if (act !== exp) begin
      failures++;
      found = 0;
      for (int i = 0; i < WORDS; i++) begin
        if (!found && act[i*WORD_W +: WORD_W] !== exp[i*WORD_W +: WORD_W]) begin
          found = 1;
          $display("FAIL %s word%0d actual=%h required=%h", name, i,
                   act[i*WORD_W +: WORD_W], exp[i*WORD_W +: WORD_W]);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.in_sel   = 1'b0;
    bus.clear    = 1'b0;
    bus.commit   = 1'b0;
    bus.mul_done = 1'b0;
  endtask

  function automatic logic [OP_W-1:0] pack_op(input bit sel);
    logic [OP_W-1:0] r;
    for (int i = 0; i < WORDS; i++) r[i*WORD_W +: WORD_W] = sel ? mb[i] : ma[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    pa = 0; pb = 0; fa = 0; fb = 0;
  endtask

  task automatic model_clear(input bit sel);
    for (int i = 0; i < WORDS; i++) begin
      if (sel) mb[i] = '0; else ma[i] = '0;
    end
    if (sel) begin pb = 0; fb = 0; end
    else begin pa = 0; fa = 0; end
  endtask

  task automatic model_write(input bit sel, input logic [31:0] val);
    if (!sel) begin
      ma[pa] = val;
      if (pa == WORDS - 1) fa = 1;
      pa = (pa + 1) % WORDS;
    end else begin
      mb[pb] = val;
      if (pb == WORDS - 1) fb = 1;
      pb = (pb + 1) % WORDS;
    end
  endtask

  task automatic check_all(input string tag);
    chk_op({tag, "_op_a"}, bus.op_a, pack_op(1'b0));
    chk_op({tag, "_op_b"}, bus.op_b, pack_op(1'b1));
    chk({tag, "_ptr_a"}, 64'(bus.ptr_a), 64'(pa));
    chk({tag, "_ptr_b"}, 64'(bus.ptr_b), 64'(pb));
    chk({tag, "_full_a"}, 64'(bus.full_a), 64'(fa));
    chk({tag, "_full_b"}, 64'(bus.full_b), 64'(fb));
  endtask

  // entered one step after the edge that sampled the start request
  task automatic wait_sequence(input int delay, input bit poke, input bit dii);
    chk("issue_busy", bus.busy, 1);
    chk("issue_ready", bus.in_ready, 0);
    chk("issue_start", bus.mul_start, 0);
    check_all("issue");
    bus.mul_done = dii;
    step();
    bus.mul_done = 1'b0;
    chk("start_pulse", bus.mul_start, 1);
    chk("wait_busy", bus.busy, 1);
    chk("wait_ready", bus.in_ready, 0);
    for (int k = 0; k < delay; k++) begin
      if (poke && k == 0) begin
        bus.in_valid = 1'b1;
        bus.in_value = 32'hDEADBEEF;
        bus.in_sel   = 1'($urandom_range(0, 1));
        bus.clear    = 1'b1;
        bus.commit   = 1'b1;
      end
      if (k == delay - 1) bus.mul_done = 1'b1;
      step();
      idle_inputs();
      if (k < delay - 1) begin
        chk("wait_start_low", bus.mul_start, 0);
        chk("wait_busy_hold", bus.busy, 1);
        chk("wait_ready_low", bus.in_ready, 0);
        check_all("wait");
      end
    end
`ifdef LOADER_AUTOSTART_EN
    fa = 0;
    fb = 0;
`endif
    chk("done_ready", bus.in_ready, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_start", bus.mul_start, 0);
    check_all("done");
  endtask

  // one LOAD-state cycle; follows through ISSUE/WAIT if the model expects a start
  task automatic cycle_load(input bit v, input bit sel, input logic [31:0] val, input bit clr,
                            input bit cmt, input bit md, input int delay, input bit poke,
                            input bit dii);
    bit both_before;
    bit trig;
    both_before  = fa && fb;
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_value = val;
    bus.clear    = clr;
    bus.commit   = cmt;
    bus.mul_done = md;
    step();
    idle_inputs();
    if (clr) model_clear(sel);
    else if (v) model_write(sel, val);
    trig = cmt;
`ifdef LOADER_AUTOSTART_EN
    if (fa && fb && !both_before) trig = 1;
`endif
    if (trig) wait_sequence(delay, poke, dii);
    else begin
      chk("load_ready", bus.in_ready, 1);
      chk("load_busy", bus.busy, 0);
      chk("load_start", bus.mul_start, 0);
      check_all("load");
    end
  endtask

  initial begin
    bit r_v, r_sel, r_clr, r_cmt, r_md, r_poke, r_dii;
    int r_dly;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 1, 0, 32'h11, 32'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h22, 1, 1, 32'h11, 32'h22};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h33, 2, 1, 32'h11, 32'h22};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 0, 1, 32'h00, 32'h22};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 0, 0, 32'h00, 32'h00};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 0, 0, 32'h00, 32'h00};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 1, 0, 32'h55, 32'h00};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1, 0, 32'h55, 32'h00};

    // clock/reset
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    step();
    step();
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.mul_start, 0);
    check_all("rst");
    #3 resetn = 1'b1;
    step();

    // vector table
    for (int i = 0; i < 8; i++) begin
      cycle_load(vecs[i].v, vecs[i].sel, vecs[i].val, vecs[i].clr, 1'b0, vecs[i].md, 1, 1'b0, 1'b0);
      chk($sformatf("vec%0d_ptr_a", i), 64'(bus.ptr_a), 64'(vecs[i].exp_pa));
      chk($sformatf("vec%0d_ptr_b", i), 64'(bus.ptr_b), 64'(vecs[i].exp_pb));
      chk($sformatf("vec%0d_a0", i), 64'(bus.op_a[31:0]), 64'(vecs[i].exp_a0));
      chk($sformatf("vec%0d_b0", i), 64'(bus.op_b[31:0]), 64'(vecs[i].exp_b0));
    end

    // op_a = 1, op_b = 3, commit; stray mul_done during ISSUE, real one 5 cycles on
    cycle_load(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    cycle_load(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    cycle_load(1'b1, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    cycle_load(1'b1, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    cycle_load(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b1);
    chk_op("basic_op_a", bus.op_a, OP_W'(1));
    chk_op("basic_op_b", bus.op_b, OP_W'(3));

    // word, clear and commit offered during WAIT are all ignored
    cycle_load(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0);
    chk_op("poke_op_a", bus.op_a, OP_W'(1));
    chk_op("poke_op_b", bus.op_b, OP_W'(3));

    // word plus commit in the same cycle
    cycle_load(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b1;
    bus.in_value = 32'h55;
    bus.commit   = 1'b1;
    step();
    idle_inputs();
    model_write(1'b1, 32'h55);
    chk("same_cycle_b0", 64'(bus.op_b[31:0]), 64'h55);
    chk("same_cycle_start", bus.mul_start, 0);
    wait_sequence(1, 1'b0, 1'b0);

    // 33 words into op_a: wrap and full flag
    cycle_load(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 33; i++) begin
      cycle_load(1'b1, 1'b0, 32'(32'h10 + i), 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      if (i == 31) begin
        chk("wrap_ptr_a", 64'(bus.ptr_a), 0);
        chk("wrap_full_a", bus.full_a, 1);
      end
    end
    chk("wrap_ptr_a_1", 64'(bus.ptr_a), 1);
    chk("wrap_full_a_hold", bus.full_a, 1);
    chk("wrap_word0", 64'(bus.op_a[31:0]), 64'h30);
    chk("wrap_word31", 64'(bus.op_a[OP_W-1 -: 32]), 64'h2F);

    // asynchronous reset in the middle of WAIT
    bus.commit = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    #3 resetn = 1'b0;
    #1;
    model_reset();
    chk("async_ready", bus.in_ready, 1);
    chk("async_busy", bus.busy, 0);
    chk("async_start", bus.mul_start, 0);
    check_all("async");
    #2 resetn = 1'b1;
    step();

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      r_v    = ($urandom_range(0, 3) != 0);
      r_sel  = 1'($urandom_range(0, 1));
      r_clr  = ($urandom_range(0, 63) == 0);
      r_cmt  = ($urandom_range(0, 39) == 0);
      r_md   = ($urandom_range(0, 7) == 0);
      r_poke = 1'($urandom_range(0, 1));
      r_dii  = 1'($urandom_range(0, 1));
      r_dly  = int'($urandom_range(1, 6));
      cycle_load(r_v, r_sel, $urandom(), r_clr, r_cmt, r_md, r_dly, r_poke, r_dii);
    end

    // fill both operands completely with no explicit commit
    cycle_load(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    cycle_load(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++)
      cycle_load(1'b1, 1'(i / 32), $urandom(), 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
`ifdef LOADER_AUTOSTART_EN
    chk("fill_full_a", bus.full_a, 0);
    chk("fill_full_b", bus.full_b, 0);
`else
    chk("fill_full_a", bus.full_a, 1);
    chk("fill_full_b", bus.full_b, 1);
`endif
    chk("fill_ready", bus.in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
